mips_div_unit: RTL and testbench

//  Multi-cycle restoring divider for MIPS DIV/DIVU; consumes the 32-bit subtractor's difference each step.

---
 rtl/mips_div_pkg.sv | 14 +
 rtl/mips_div_if.sv | 24 ++
 rtl/div_trial_sub.sv | 16 +
 rtl/mips_div_unit.sv | 152 +++++++++++++++
 tb/tb_mips_div_unit.sv | 134 +++++++++++++
 5 files changed

// File: rtl/mips_div_pkg.sv
// Shared types and sizing for the MIPS DIV/DIVU multi-cycle divider.
package mips_div_pkg;

    localparam int unsigned DIV_WIDTH = 32;
    localparam int unsigned DIV_CNT_W = $clog2(DIV_WIDTH);

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StFix,
        StDone
    } div_state_e;

endpackage

// File: rtl/mips_div_if.sv
// Request/result bundle between the EX stage and the divider.
interface mips_div_if #(
    parameter int unsigned WIDTH = 32
);
    logic             start;
    logic             is_signed;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             busy;
    logic             done;
    logic             div_zero;
    logic [WIDTH-1:0] lo;
    logic [WIDTH-1:0] hi;

    modport master (
        output start, is_signed, dividend, divisor,
        input  busy, done, div_zero, lo, hi
    );

    modport slave (
        input  start, is_signed, dividend, divisor,
        output busy, done, div_zero, lo, hi
    );
endinterface

// File: rtl/div_trial_sub.sv
// Combinational WIDTH+1-bit trial subtract, built as a + ~b + 1 like the ALU subtractor.
module div_trial_sub #(
    parameter int unsigned WIDTH = 32
) (
    input  logic [WIDTH:0] a_i,
    input  logic [WIDTH:0] b_i,
    output logic [WIDTH:0] diff_o,
    output logic           no_borrow_o
);
    logic [WIDTH+1:0] sum;

    // Carry out of the top bit is set exactly when a_i >= b_i.
    assign sum         = {1'b0, a_i} + {1'b0, ~b_i} + {{(WIDTH + 1){1'b0}}, 1'b1};
    assign diff_o      = sum[WIDTH:0];
    assign no_borrow_o = sum[WIDTH+1];
endmodule

// File: rtl/mips_div_unit.sv
// Multi-cycle restoring divider for DIV/DIVU: quotient to lo, remainder to hi.
// Signed support (abs at accept, sign fix-up) is built only with MIPS_DIV_SIGNED_EN defined.
module mips_div_unit
    import mips_div_pkg::*;
#(
    parameter int unsigned WIDTH = DIV_WIDTH,
    parameter int unsigned CNT_W = DIV_CNT_W
) (
    input logic      clk,
    input logic      rst,
    mips_div_if.slave bus
);
    div_state_e       state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] dsor_q, dsor_d;
    logic [WIDTH-1:0] dend_q, dend_d;
    logic             neg_quo_q, neg_quo_d;
    logic             neg_rem_q, neg_rem_d;
    logic             zero_q, zero_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             div_zero_q, div_zero_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic [WIDTH-1:0] hi_q, hi_d;

    logic             neg_a, neg_b;
    logic [WIDTH-1:0] mag_a, mag_b;
    logic [WIDTH:0]   trial_a, trial_diff;
    logic             no_borrow;
    logic             unused_diff_msb;

`ifdef MIPS_DIV_SIGNED_EN
    assign neg_a = bus.is_signed & bus.dividend[WIDTH-1];
    assign neg_b = bus.is_signed & bus.divisor[WIDTH-1];
`else
    assign neg_a = 1'b0;
    assign neg_b = 1'b0;
`endif
    assign mag_a = neg_a ? -bus.dividend : bus.dividend;
    assign mag_b = neg_b ? -bus.divisor : bus.divisor;

    // Keep the remainder's top bit in the trial so divisors >= 2^(WIDTH-1) still work.
    assign trial_a         = {rem_q, quo_q[WIDTH-1]};
    assign unused_diff_msb = trial_diff[WIDTH];

    div_trial_sub #(
        .WIDTH(WIDTH)
    ) u_trial_sub (
        .a_i        (trial_a),
        .b_i        ({1'b0, dsor_q}),
        .diff_o     (trial_diff),
        .no_borrow_o(no_borrow)
    );

    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        rem_d      = rem_q;
        quo_d      = quo_q;
        dsor_d     = dsor_q;
        dend_d     = dend_q;
        neg_quo_d  = neg_quo_q;
        neg_rem_d  = neg_rem_q;
        zero_d     = zero_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        div_zero_d = div_zero_q;
        lo_d       = lo_q;
        hi_d       = hi_q;

        unique case (state_q)
            StIdle: begin
                if (bus.start) begin
                    rem_d     = '0;
                    quo_d     = mag_a;
                    dsor_d    = mag_b;
                    dend_d    = bus.dividend;
                    neg_quo_d = neg_a ^ neg_b;
                    neg_rem_d = neg_a;
                    zero_d    = (bus.divisor == '0);
                    count_d   = CNT_W'(WIDTH - 1);
                    busy_d    = 1'b1;
                    state_d   = StRun;
                end
            end
            StRun: begin
                quo_d   = {quo_q[WIDTH-2:0], no_borrow};
                rem_d   = no_borrow ? trial_diff[WIDTH-1:0] : trial_a[WIDTH-1:0];
                count_d = count_q - 1'b1;
                if (count_q == '0) begin
                    state_d = StFix;
                end
            end
            StFix: begin
                if (!zero_q && neg_quo_q) quo_d = -quo_q;
                if (!zero_q && neg_rem_q) rem_d = -rem_q;
                state_d = StDone;
            end
            StDone: begin
                lo_d       = zero_q ? '1 : quo_q;
                hi_d       = zero_q ? dend_q : rem_q;
                div_zero_d = zero_q;
                done_d     = 1'b1;
                busy_d     = 1'b0;
                state_d    = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            count_q    <= '0;
            rem_q      <= '0;
            quo_q      <= '0;
            dsor_q     <= '0;
            dend_q     <= '0;
            neg_quo_q  <= 1'b0;
            neg_rem_q  <= 1'b0;
            zero_q     <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            div_zero_q <= 1'b0;
            lo_q       <= '0;
            hi_q       <= '0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            rem_q      <= rem_d;
            quo_q      <= quo_d;
            dsor_q     <= dsor_d;
            dend_q     <= dend_d;
            neg_quo_q  <= neg_quo_d;
            neg_rem_q  <= neg_rem_d;
            zero_q     <= zero_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            div_zero_q <= div_zero_d;
            lo_q       <= lo_d;
            hi_q       <= hi_d;
        end
    end

    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.div_zero = div_zero_q;
    assign bus.lo       = lo_q;
    assign bus.hi       = hi_q;
endmodule

// File: tb/tb_mips_div_unit.sv
// Directed bench for mips_div_unit; expectations switch with MIPS_DIV_SIGNED_EN.
module tb_mips_div_unit;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_err = 0;

    mips_div_if #(.WIDTH(32)) bus ();

    mips_div_unit #(.WIDTH(32)) u_dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, act, exp);
        end
    endtask

    // Issue one divide; optionally pulse a second start at cycle inj while busy.
    task automatic do_div(input string tag, input logic sgn, input logic [31:0] a,
                          input logic [31:0] b, input int inj, input logic [31:0] exp_lo,
                          input logic [31:0] exp_hi, input logic exp_z);
        int   lat;
        logic got;
        bus.is_signed = sgn;
        bus.dividend  = a;
        bus.divisor   = b;
        bus.start     = 1'b1;
        @(posedge clk);
        #1;
        bus.start    = 1'b0;
        bus.dividend = ~a;
        bus.divisor  = ~b;
        check({tag, ":busy"}, {31'd0, bus.busy}, 32'd1);
        lat = 0;
        got = 1'b0;
        while (!got && lat < 60) begin
            if (lat == inj) begin
                bus.start    = 1'b1;
                bus.dividend = 32'd999;
                bus.divisor  = 32'd3;
            end
            @(posedge clk);
            #1;
            bus.start = 1'b0;
            lat++;
            if (bus.done) got = 1'b1;
        end
        check({tag, ":latency"}, lat, 32'd34);
        check({tag, ":lo"}, bus.lo, exp_lo);
        check({tag, ":hi"}, bus.hi, exp_hi);
        check({tag, ":div_zero"}, {31'd0, bus.div_zero}, {31'd0, exp_z});
        check({tag, ":busy_end"}, {31'd0, bus.busy}, 32'd0);
        @(posedge clk);
        #1;
        check({tag, ":done_pulse"}, {31'd0, bus.done}, 32'd0);
        check({tag, ":lo_hold"}, bus.lo, exp_lo);
    endtask

    initial begin
        int n_done;
        bus.start     = 1'b0;
        bus.is_signed = 1'b0;
        bus.dividend  = '0;
        bus.divisor   = '0;
        #1;
        check("rst:busy", {31'd0, bus.busy}, 32'd0);
        check("rst:done", {31'd0, bus.done}, 32'd0);
        check("rst:lo", bus.lo, 32'd0);
        check("rst:hi", bus.hi, 32'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;

        do_div("divu_100_7", 1'b0, 32'd100, 32'd7, -1, 32'd14, 32'd2, 1'b0);
        do_div("divu_max_1", 1'b0, 32'hFFFF_FFFF, 32'd1, -1, 32'hFFFF_FFFF, 32'd0, 1'b0);
        do_div("divu_lt", 1'b0, 32'h1234_5678, 32'h1234_5679, -1, 32'd0, 32'h1234_5678, 1'b0);
        do_div("divu_bigdiv", 1'b0, 32'hFFFF_FFFE, 32'h8000_0001, -1, 32'd1, 32'h7FFF_FFFD,
               1'b0);
`ifdef MIPS_DIV_SIGNED_EN
        do_div("div_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2, -1, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0);
        do_div("div_7_m2", 1'b1, 32'd7, 32'hFFFF_FFFE, -1, 32'hFFFF_FFFD, 32'd1, 1'b0);
        do_div("div_min_m1", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, -1, 32'h8000_0000, 32'd0, 1'b0);
`else
        do_div("div_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2, -1, 32'h7FFF_FFFC, 32'd1, 1'b0);
        do_div("div_7_m2", 1'b1, 32'd7, 32'hFFFF_FFFE, -1, 32'd0, 32'd7, 1'b0);
        do_div("div_min_m1", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, -1, 32'd0, 32'h8000_0000, 1'b0);
`endif
        do_div("divz_55", 1'b0, 32'd55, 32'd0, -1, 32'hFFFF_FFFF, 32'd55, 1'b1);
        do_div("divz_m5", 1'b1, 32'hFFFF_FFFB, 32'd0, -1, 32'hFFFF_FFFF, 32'hFFFF_FFFB, 1'b1);
        do_div("busy_start", 1'b0, 32'd1000, 32'd7, 10, 32'd142, 32'd6, 1'b0);

        // Abort a divide with reset in its fifth cycle, after a result with nonzero lo/hi.
        do_div("pre_abort", 1'b0, 32'd55, 32'd0, -1, 32'hFFFF_FFFF, 32'd55, 1'b1);
        bus.is_signed = 1'b0;
        bus.dividend  = 32'd500;
        bus.divisor   = 32'd9;
        bus.start     = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("abort:busy", {31'd0, bus.busy}, 32'd0);
        check("abort:done", {31'd0, bus.done}, 32'd0);
        check("abort:div_zero", {31'd0, bus.div_zero}, 32'd0);
        check("abort:lo", bus.lo, 32'd0);
        check("abort:hi", bus.hi, 32'd0);
        @(posedge clk);
        #1;
        rst    = 1'b0;
        n_done = 0;
        for (int i = 0; i < 45; i++) begin
            @(posedge clk);
            #1;
            if (bus.done || bus.busy) n_done++;
        end
        check("abort:no_done", n_done, 32'd0);
        do_div("after_abort", 1'b0, 32'd500, 32'd9, -1, 32'd55, 32'd5, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
